// File: rtl/stream_slice_unpack_if.sv
// Word-rebuild link between a slice-serial sender and a word-wide consumer.
// master = beat source / word sink (bench or upstream), slave = the unpacker.
interface stream_slice_unpack_if #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 8
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [SLICE_W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic               busy;
  logic [15:0]        beat_dbg;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, beat_dbg
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, beat_dbg
  );
endinterface

// File: rtl/stream_slice_unpack.sv
// Rebuilds a DATA_W word from SLICE_W beats sent as {<< SLICE_W {w}} (LEFT=1)
// or {>> SLICE_W {w}} (LEFT=0); beat counter plus one-word output stage.
module stream_slice_unpack #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 8,
  parameter bit LEFT    = 1'b1
) (
  input logic                  clk,
  input logic                  reset_l,
  stream_slice_unpack_if.slave bus
);
  // Handshake: a transfer happens on a posedge where valid & ready are both 1;
  // valid never waits on ready, and in_ready is low whenever a finished word
  // is still waiting to be taken.
  localparam int NSLICE = (DATA_W + SLICE_W - 1) / SLICE_W;
  localparam int REM    = DATA_W - (NSLICE - 1) * SLICE_W;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int WW     = DATA_W + SLICE_W;
  localparam logic [KW-1:0] K_LAST   = KW'(NSLICE - 1);
  localparam logic [WW-1:0] REM_MASK = (WW'(1) << REM) - WW'(1);

  logic [KW-1:0]     k_q, k_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              ov_q, ov_d;
  logic              in_ready;
  logic              accept;
  logic              last;
  logic [WW-1:0]     beat;
  int                sh;
  logic [DATA_W-1:0] word;

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      k_q   <= '0;
      acc_q <= '0;
      out_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      k_q   <= k_d;
      acc_q <= acc_d;
      out_q <= out_d;
      ov_q  <= ov_d;
    end
  end

  always_comb begin
    in_ready = !(ov_q && !bus.out_ready);
    accept   = bus.in_valid && in_ready && !bus.flush;
    last     = (k_q == K_LAST);

    // Last beat only carries REM meaningful bits; the rest must not leak in.
    beat = WW'(bus.in_data);
    if (last) beat = beat & REM_MASK;

    if (LEFT) sh = int'(k_q) * SLICE_W;
    else if (last) sh = 0;
    else sh = DATA_W - (int'(k_q) + 1) * SLICE_W;

    // Each bit position is written once per word into a zeroed accumulator.
    word = acc_q | DATA_W'(beat << sh);

    k_d   = k_q;
    acc_d = acc_q;
    out_d = out_q;
    ov_d  = ov_q;

    if (ov_q && bus.out_ready) ov_d = 1'b0;

    if (bus.flush) begin
      k_d   = '0;
      acc_d = '0;
    end else if (accept) begin
      if (last) begin
        k_d   = '0;
        acc_d = '0;
        out_d = word;
        ov_d  = 1'b1;
      end else begin
        k_d   = k_q + KW'(1);
        acc_d = word;
      end
    end
  end

  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = ov_q;
    bus.out_data  = out_q;
    bus.busy      = (k_q != '0);
    bus.beat_dbg  = 16'(k_q);
  end
endmodule

// File: tb/tb_stream_slice_unpack.sv
// Directed bench: several parameterisations of the unpacker share one clock
// and reset; expected words are worked out by hand from the beat placement.
module tb_stream_slice_unpack;
  logic clk;
  logic reset_l;
  int   n_cmp;
  int   n_fail;

  stream_slice_unpack_if #(.DATA_W(32), .SLICE_W(8)) b0 ();
  stream_slice_unpack_if #(.DATA_W(32), .SLICE_W(8)) b1 ();
  stream_slice_unpack_if #(.DATA_W(4),  .SLICE_W(3)) b2 ();
  stream_slice_unpack_if #(.DATA_W(4),  .SLICE_W(2)) b3 ();
  stream_slice_unpack_if #(.DATA_W(4),  .SLICE_W(5)) b4 ();

  stream_slice_unpack #(.DATA_W(32), .SLICE_W(8), .LEFT(1'b1)) u0 (.clk(clk), .reset_l(reset_l), .bus(b0));
  stream_slice_unpack #(.DATA_W(32), .SLICE_W(8), .LEFT(1'b0)) u1 (.clk(clk), .reset_l(reset_l), .bus(b1));
  stream_slice_unpack #(.DATA_W(4),  .SLICE_W(3), .LEFT(1'b1)) u2 (.clk(clk), .reset_l(reset_l), .bus(b2));
  stream_slice_unpack #(.DATA_W(4),  .SLICE_W(2), .LEFT(1'b1)) u3 (.clk(clk), .reset_l(reset_l), .bus(b3));
  stream_slice_unpack #(.DATA_W(4),  .SLICE_W(5), .LEFT(1'b1)) u4 (.clk(clk), .reset_l(reset_l), .bus(b4));

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat0(input logic [7:0] d);
    b0.in_valid = 1'b1;
    b0.in_data  = d;
    step();
    b0.in_valid = 1'b0;
  endtask

  // scoreboard for the continuous-stream run on the LEFT=0 instance
  logic [31:0] exp_q[$];

  initial begin
    logic [7:0] stream1 [8];
    logic [31:0] exp_w;
    n_cmp = 0;
    n_fail = 0;
    reset_l = 1'b0;
    b0.flush = 0; b0.in_valid = 0; b0.in_data = '0; b0.out_ready = 1;
    b1.flush = 0; b1.in_valid = 0; b1.in_data = '0; b1.out_ready = 1;
    b2.flush = 0; b2.in_valid = 0; b2.in_data = '0; b2.out_ready = 1;
    b3.flush = 0; b3.in_valid = 0; b3.in_data = '0; b3.out_ready = 1;
    b4.flush = 0; b4.in_valid = 0; b4.in_data = '0; b4.out_ready = 1;
    step();
    step();
    reset_l = 1'b1;
    chk("rst_out_valid", 64'(b0.out_valid), 64'd0);
    chk("rst_out_data", 64'(b0.out_data), 64'd0);
    chk("rst_busy", 64'(b0.busy), 64'd0);
    chk("rst_in_ready", 64'(b0.in_ready), 64'd1);

    // basic LEFT=1 and LEFT=0 words
    for (int i = 0; i < 4; i++) begin
      b0.in_valid = 1; b0.in_data = 8'(i + 1);
      b1.in_valid = 1; b1.in_data = 8'(4 - i);
      step();
      chk("t1_busy", 64'(b0.busy), (i < 3) ? 64'd1 : 64'd0);
      chk("t1_valid", 64'(b0.out_valid), (i == 3) ? 64'd1 : 64'd0);
    end
    b0.in_valid = 0; b1.in_valid = 0;
    chk("t1_left1_word", 64'(b0.out_data), 64'h04030201);
    chk("t2_left0_word", 64'(b1.out_data), 64'h04030201);
    step();
    chk("t1_consumed", 64'(b0.out_valid), 64'd0);

    // back-to-back words on LEFT=0 with out_ready held high
    stream1 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_q.push_back(32'hAABBCCDD);
    exp_q.push_back(32'h11223344);
    for (int i = 0; i < 8; i++) begin
      b1.in_valid = 1; b1.in_data = stream1[i];
      chk("t2_in_ready", 64'(b1.in_ready), 64'd1);
      step();
      chk("t2_valid", 64'(b1.out_valid), (i == 3 || i == 7) ? 64'd1 : 64'd0);
      if (b1.out_valid) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        chk("t2_word", 64'(b1.out_data), 64'(exp_w));
      end
    end
    b1.in_valid = 0;
    chk("t2_all_words", 64'(exp_q.size()), 64'd0);

    // narrow words, including the single-beat case and ignored upper bits
    b2.in_valid = 1; b2.in_data = 3'b001;
    b3.in_valid = 1; b3.in_data = 2'b00;
    b4.in_valid = 1; b4.in_data = 5'b00001;
    step();
    chk("t3_s5_valid", 64'(b4.out_valid), 64'd1);
    chk("t3_s5_word", 64'(b4.out_data), 64'h1);
    chk("t3_s3_busy", 64'(b2.busy), 64'd1);
    b2.in_data = 3'b000; b3.in_data = 2'b01; b4.in_data = 5'b11010;
    step();
    chk("t3_s3_word", 64'(b2.out_data), 64'h1);
    chk("t3_s2_word", 64'(b3.out_data), 64'h4);
    chk("t3_s5_refill_valid", 64'(b4.out_valid), 64'd1);
    chk("t3_s5_refill_word", 64'(b4.out_data), 64'hA);
    b4.in_valid = 0;
    b2.in_data = 3'b110; b3.in_data = 2'b10;
    step();
    b2.in_data = 3'b111; b3.in_data = 2'b11;
    step();
    b2.in_valid = 0; b3.in_valid = 0;
    chk("t3_s3_masked", 64'(b2.out_data), 64'hE);
    chk("t3_s2_word2", 64'(b3.out_data), 64'hE);

    // backpressure: held word stalls every beat; flush leaves it alone
    b0.out_ready = 0;
    beat0(8'h01); beat0(8'h02); beat0(8'h03); beat0(8'h04);
    chk("t4_held_valid", 64'(b0.out_valid), 64'd1);
    chk("t4_in_ready_low", 64'(b0.in_ready), 64'd0);
    b0.in_valid = 1; b0.in_data = 8'h55;
    step();
    step();
    chk("t4_held_word", 64'(b0.out_data), 64'h04030201);
    chk("t4_no_accept", 64'(b0.busy), 64'd0);
    b0.in_valid = 0; b0.flush = 1;
    step();
    b0.flush = 0;
    chk("t4_flush_keeps_out", 64'(b0.out_valid), 64'd1);
    b0.in_valid = 1; b0.out_ready = 1;
    #1;
    chk("t4_in_ready_comb", 64'(b0.in_ready), 64'd1);
    step();
    chk("t4_a_taken", 64'(b0.out_valid), 64'd0);
    chk("t4_b_first", 64'(b0.busy), 64'd1);
    beat0(8'h66); beat0(8'h77); beat0(8'h88);
    chk("t4_b_word", 64'(b0.out_data), 64'h88776655);

    // flush mid-word, then flush coincident with a beat
    beat0(8'hAA); beat0(8'hBB);
    chk("t5_busy_before", 64'(b0.busy), 64'd1);
    b0.flush = 1;
    step();
    b0.flush = 0;
    chk("t5_flushed", 64'(b0.busy), 64'd0);
    beat0(8'h11); beat0(8'h22); beat0(8'h33); beat0(8'h44);
    chk("t5_word", 64'(b0.out_data), 64'h44332211);
    beat0(8'h99);
    b0.flush = 1; b0.in_valid = 1; b0.in_data = 8'hEE;
    step();
    b0.flush = 0; b0.in_valid = 0;
    chk("t5_beat_dropped", 64'(b0.beat_dbg), 64'd0);
    beat0(8'h11); beat0(8'h22); beat0(8'h33);
    chk("t5_not_early", 64'(b0.out_valid), 64'd0);
    beat0(8'h44);
    chk("t5_word2", 64'(b0.out_data), 64'h44332211);

    // reset mid-word with a beat offered in the reset cycle
    beat0(8'h12); beat0(8'h34); beat0(8'h56);
    reset_l = 0; b0.in_valid = 1; b0.in_data = 8'hFF;
    step();
    reset_l = 1; b0.in_valid = 0;
    chk("t6_busy", 64'(b0.busy), 64'd0);
    chk("t6_valid", 64'(b0.out_valid), 64'd0);
    chk("t6_data", 64'(b0.out_data), 64'd0);
    // reset with a held word
    b0.out_ready = 0;
    beat0(8'h01); beat0(8'h02); beat0(8'h03); beat0(8'h04);
    chk("t6_held", 64'(b0.out_valid), 64'd1);
    reset_l = 0;
    step();
    reset_l = 1; b0.out_ready = 1;
    chk("t6_held_dropped", 64'(b0.out_valid), 64'd0);
    beat0(8'hA1); beat0(8'hB2); beat0(8'hC3); beat0(8'hD4);
    chk("t6_clean_word", 64'(b0.out_data), 64'hD4C3B2A1);
    chk("t6_clean_valid", 64'(b0.out_valid), 64'd1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
